dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port Data_Memory. It shares the memory between the CPU MEM stage (port A) and the debug/loader port (port B). Each request is held on the memory's MemRead/MemWrite strobes for a fixed number of cycles, then returned to its requester with a one-cycle ack. Sits between the MEM-stage pipeline register and Data_Memory; `a_ack_o` drives the pipeline stall logic.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter_rr_pick2.sv | 30 +++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port identifiers and the counter sizing helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // The counter only needs to hold LATENCY-1; keep it at least one bit wide.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and Data_Memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              a_req_i;
    logic              a_we_i;
    logic [ADDR_W-1:0] a_addr_i;
    logic [DATA_W-1:0] a_wdata_i;
    logic              a_ack_o;
    logic [DATA_W-1:0] a_rdata_o;

    logic              b_req_i;
    logic              b_we_i;
    logic [ADDR_W-1:0] b_addr_i;
    logic [DATA_W-1:0] b_wdata_i;
    logic              b_ack_o;
    logic [DATA_W-1:0] b_rdata_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
        output a_ack_o, a_rdata_o,
        input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
        output b_ack_o, b_rdata_o,
        output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
        input  mem_rdata_i
    );

    modport master (
        output a_req_i, a_we_i, a_addr_i, a_wdata_i,
        input  a_ack_o, a_rdata_o,
        output b_req_i, b_we_i, b_addr_i, b_wdata_i,
        input  b_ack_o, b_rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick. With mask_last set, the port named
// by last is excluded (used while that port is still holding req during its ack).
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    input  logic mask_last,
    output logic winner,
    output logic valid
);

    logic elig_a;
    logic elig_b;

    assign elig_a = req_a & ~(mask_last & (last == PORT_A));
    assign elig_b = req_b & ~(mask_last & (last == PORT_B));
    assign valid  = elig_a | elig_b;

    always_comb begin
        winner = PORT_A;
        if (elig_a && elig_b) begin
            winner = ~last;
        end else if (elig_b) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing one single-port Data_Memory between the CPU MEM
// stage (port A) and the debug/loader port (port B).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_arbiter_if.slave   bus,
    output logic            busy_o,
    output logic            grant_o
);

    localparam int              CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_q;
    logic              last_grant_q;
    logic              a_ack_q;
    logic              b_ack_q;

    logic pick_last;
    logic pick_mask;
    logic pick_winner;
    logic pick_valid;
    logic load_cmd;
    logic finish;

    // In RESP the port being acked still holds req, so it is masked out.
    assign pick_mask = (state_q == RESP);
    assign pick_last = pick_mask ? grant_q : last_grant_q;

    rr_pick2 u_pick (
        .req_a     (bus.a_req_i),
        .req_b     (bus.b_req_i),
        .last      (pick_last),
        .mask_last (pick_mask),
        .winner    (pick_winner),
        .valid     (pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_cmd = 1'b0;
        finish   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    load_cmd = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (pick_valid) begin
                    load_cmd = 1'b1;
                    state_d  = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command, counter, grant and read-data registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q        <= '0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rdata_q      <= '0;
            grant_q      <= PORT_A;
            last_grant_q <= PORT_B;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
        end else begin
            a_ack_q <= finish && (grant_q == PORT_A);
            b_ack_q <= finish && (grant_q == PORT_B);
            if (load_cmd) begin
                cmd_we_q     <= (pick_winner == PORT_B) ? bus.b_we_i    : bus.a_we_i;
                cmd_addr_q   <= (pick_winner == PORT_B) ? bus.b_addr_i  : bus.a_addr_i;
                cmd_wdata_q  <= (pick_winner == PORT_B) ? bus.b_wdata_i : bus.a_wdata_i;
                cnt_q        <= CNT_LOAD;
                grant_q      <= pick_winner;
                last_grant_q <= pick_winner;
            end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (finish && !cmd_we_q) begin
                rdata_q <= bus.mem_rdata_i;
            end
        end
    end

    // Memory side is driven only in ACCESS so reset drops the strobes at once.
    assign bus.mem_read_o  = (state_q == ACCESS) & ~cmd_we_q;
    assign bus.mem_write_o = (state_q == ACCESS) &  cmd_we_q;
    assign bus.mem_addr_o  = (state_q == ACCESS) ? cmd_addr_q  : '0;
    assign bus.mem_wdata_o = (state_q == ACCESS) ? cmd_wdata_q : '0;

    assign bus.a_ack_o   = a_ack_q;
    assign bus.b_ack_o   = b_ack_q;
    assign bus.a_rdata_o = rdata_q;
    assign bus.b_rdata_o = rdata_q;

    assign busy_o  = (state_q == ACCESS) || (state_q == RESP);
    assign grant_o = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a LATENCY=2 instance for the main scenarios
// and a LATENCY=1 instance for the minimum-latency case, each on a word memory model.
module tb_dmem_arbiter;

    logic clk;
    logic rst_n;
    logic busy0, grant0, busy1, grant1;
    int   checks;
    int   errors;

    logic [31:0] mem [0:255];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    dmem_arbiter #(.LATENCY(2), .ADDR_W(32), .DATA_W(32)) dut0 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .bus     (bus0.slave),
        .busy_o  (busy0),
        .grant_o (grant0)
    );

    dmem_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .bus     (bus1.slave),
        .busy_o  (busy1),
        .grant_o (grant1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus0.mem_rdata_i = mem[bus0.mem_addr_o[7:0]];
    assign bus1.mem_rdata_i = mem[bus1.mem_addr_o[7:0]];

    always @(posedge clk) begin
        if (bus0.mem_write_o) mem[bus0.mem_addr_o[7:0]] <= bus0.mem_wdata_o;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus0.a_req_i = 1'b0;
        bus0.b_req_i = 1'b0;
        bus1.a_req_i = 1'b0;
        bus1.b_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issues one request on bus0 from an IDLE cycle and tallies what the memory side sees.
    task automatic apply_stimulus(input logic port, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, output int ack_cycle,
                                  output int rd_cycles, output int wr_cycles,
                                  output int other_ack, output logic [31:0] rdata,
                                  output logic [31:0] strobe_addr,
                                  output logic [31:0] strobe_wdata);
        ack_cycle = -1; rd_cycles = 0; wr_cycles = 0; other_ack = 0;
        rdata = '0; strobe_addr = '0; strobe_wdata = '0;
        if (port == 1'b0) begin
            bus0.a_we_i = we; bus0.a_addr_i = addr; bus0.a_wdata_i = wdata; bus0.a_req_i = 1'b1;
        end else begin
            bus0.b_we_i = we; bus0.b_addr_i = addr; bus0.b_wdata_i = wdata; bus0.b_req_i = 1'b1;
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus0.mem_read_o)  rd_cycles++;
            if (bus0.mem_write_o) begin
                wr_cycles++;
                strobe_wdata = bus0.mem_wdata_o;
            end
            if (bus0.mem_read_o || bus0.mem_write_o) strobe_addr = bus0.mem_addr_o;
            if ((port == 1'b0) ? bus0.b_ack_o : bus0.a_ack_o) other_ack++;
            if ((port == 1'b0) ? bus0.a_ack_o : bus0.b_ack_o) begin
                ack_cycle = i;
                rdata = (port == 1'b0) ? bus0.a_rdata_o : bus0.b_rdata_o;
                bus0.a_req_i = 1'b0;
                bus0.b_req_i = 1'b0;
                break;
            end
        end
        if (ack_cycle < 0) begin
            bus0.a_req_i = 1'b0;
            bus0.b_req_i = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          ack_c, rd_c, wr_c, oth, t_a, t_b, gap, n, both, t1, rd1, oth1;
        logic [31:0] rd_v, s_addr, s_wdata, b_rd;
        logic        order [0:5];
        int          cyc [0:5];

        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4] = 32'h0000_005A;

        rst_n = 1'b0;
        bus0.a_req_i = 0; bus0.a_we_i = 0; bus0.a_addr_i = 0; bus0.a_wdata_i = 0;
        bus0.b_req_i = 0; bus0.b_we_i = 0; bus0.b_addr_i = 0; bus0.b_wdata_i = 0;
        bus1.a_req_i = 0; bus1.a_we_i = 0; bus1.a_addr_i = 0; bus1.a_wdata_i = 0;
        bus1.b_req_i = 0; bus1.b_we_i = 0; bus1.b_addr_i = 0; bus1.b_wdata_i = 0;

        #12;
        check_output("reset_a_ack",   64'(bus0.a_ack_o),     64'd0);
        check_output("reset_b_ack",   64'(bus0.b_ack_o),     64'd0);
        check_output("reset_read",    64'(bus0.mem_read_o),  64'd0);
        check_output("reset_write",   64'(bus0.mem_write_o), 64'd0);
        check_output("reset_addr",    64'(bus0.mem_addr_o),  64'd0);
        check_output("reset_wdata",   64'(bus0.mem_wdata_o), 64'd0);
        check_output("reset_rdata",   64'(bus0.a_rdata_o),   64'd0);
        check_output("reset_busy",    64'(busy0),            64'd0);
        check_output("reset_grant",   64'(grant0),           64'd0);

        do_reset();

        $display("[TB] single read");
        apply_stimulus(1'b0, 1'b0, 32'd4, 32'd0, ack_c, rd_c, wr_c, oth, rd_v, s_addr, s_wdata);
        check_output("rd_ack_cycle",  64'(ack_c),  64'd3);
        check_output("rd_strobe_cyc", 64'(rd_c),   64'd2);
        check_output("rd_no_write",   64'(wr_c),   64'd0);
        check_output("rd_addr",       64'(s_addr), 64'd4);
        check_output("rd_data",       64'(rd_v),   64'h5A);

        $display("[TB] write then read");
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 32'd7, 32'h3C, ack_c, rd_c, wr_c, oth, rd_v, s_addr, s_wdata);
        check_output("wr_ack_cycle",  64'(ack_c),   64'd3);
        check_output("wr_strobe_cyc", 64'(wr_c),    64'd2);
        check_output("wr_no_read",    64'(rd_c),    64'd0);
        check_output("wr_addr",       64'(s_addr),  64'd7);
        check_output("wr_wdata",      64'(s_wdata), 64'h3C);
        check_output("wr_rdata_kept", 64'(rd_v),    64'h5A);
        check_output("wr_no_b_ack",   64'(oth),     64'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 32'd7, 32'd0, ack_c, rd_c, wr_c, oth, rd_v, s_addr, s_wdata);
        check_output("rb_ack_cycle",  64'(ack_c), 64'd3);
        check_output("rb_data",       64'(rd_v),  64'h3C);
        check_output("rb_no_b_ack",   64'(oth),   64'd0);

        $display("[TB] tie after reset");
        do_reset();
        bus0.a_we_i = 0; bus0.a_addr_i = 32'd4;
        bus0.b_we_i = 0; bus0.b_addr_i = 32'd7;
        bus0.a_req_i = 1; bus0.b_req_i = 1;
        t_a = -1; t_b = -1; gap = 0; b_rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((t_a > 0) && !busy0) gap++;
            if (bus0.a_ack_o && (t_b < 0) && (t_a < 0)) begin
                t_a = i;
                bus0.a_req_i = 0;
            end
            if (bus0.b_ack_o) begin
                t_b = i;
                b_rd = bus0.b_rdata_o;
                bus0.b_req_i = 0;
                break;
            end
        end
        bus0.a_req_i = 0; bus0.b_req_i = 0;
        check_output("tie_a_first",  64'(t_a),  64'd3);
        check_output("tie_b_after",  64'(t_b),  64'd6);
        check_output("tie_no_idle",  64'(gap),  64'd0);
        check_output("tie_b_rdata",  64'(b_rd), 64'h3C);

        $display("[TB] continuous contention");
        @(negedge clk);
        bus0.a_req_i = 1; bus0.b_req_i = 1;
        n = 0; both = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus0.a_ack_o && bus0.b_ack_o) both++;
            if (bus0.a_ack_o || bus0.b_ack_o) begin
                order[n] = bus0.b_ack_o;
                cyc[n] = i;
                n++;
                if (n == 6) begin
                    bus0.a_req_i = 0; bus0.b_req_i = 0;
                    break;
                end
            end
        end
        bus0.a_req_i = 0; bus0.b_req_i = 0;
        check_output("cont_ops", 64'(n), 64'd6);
        check_output("cont_both_ack", 64'(both), 64'd0);
        for (int k = 0; k < n; k++) begin
            check_output($sformatf("cont_port_%0d", k), 64'(order[k]), 64'(k % 2));
            check_output($sformatf("cont_cycle_%0d", k), 64'(cyc[k]), 64'(3 + 3 * k));
        end

        $display("[TB] reset mid-operation");
        @(negedge clk);
        @(negedge clk);
        bus0.b_we_i = 0; bus0.b_addr_i = 32'd4; bus0.b_req_i = 1;
        @(negedge clk);
        check_output("mid_strobe_on", 64'(bus0.mem_read_o), 64'd1);
        check_output("mid_grant_b",   64'(grant0),          64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        bus0.b_req_i = 0;
        #1;
        check_output("mid_strobe_off", 64'(bus0.mem_read_o), 64'd0);
        check_output("mid_addr_zero",  64'(bus0.mem_addr_o), 64'd0);
        check_output("mid_busy_off",   64'(busy0),           64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        oth = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus0.a_ack_o || bus0.b_ack_o) oth++;
        end
        check_output("mid_no_ack",   64'(oth),    64'd0);
        check_output("mid_grant_a",  64'(grant0), 64'd0);
        check_output("mid_idle",     64'(busy0),  64'd0);

        $display("[TB] minimum latency");
        @(negedge clk);
        bus1.b_we_i = 0; bus1.b_addr_i = 32'd4; bus1.b_req_i = 1;
        t1 = -1; rd1 = 0; oth1 = 0; rd_v = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus1.mem_read_o) rd1++;
            if (bus1.a_ack_o) oth1++;
            if (bus1.b_ack_o) begin
                t1 = i;
                rd_v = bus1.b_rdata_o;
                bus1.b_req_i = 0;
                break;
            end
        end
        bus1.b_req_i = 0;
        check_output("lat1_strobe_cyc", 64'(rd1),  64'd1);
        check_output("lat1_ack_cycle",  64'(t1),   64'd2);
        check_output("lat1_rdata",      64'(rd_v), 64'h5A);
        check_output("lat1_no_a_ack",   64'(oth1), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
